// File: rtl/seg7_scan_driver_if.sv
// Digit-bus bundle between the game controller and the display scanner.
// The master side drives the digit codes and blink mask. The slave side drives the display pins.
interface seg7_scan_driver_if;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output dig0, dig1, dig2, dig3, blink,
    input  an, seg, dp
  );

  modport slave (
    input  dig0, dig1, dig2, dig3, blink,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scanner with per-frame input latch and blink.
// All outputs are registered and change only on slot ticks.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  disp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] p;
    case (code)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      4'd10:   p = 7'b0111111;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          ph_q, ph_d;
  logic [3:0]    blk_q, blk_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    shadow_q [4];
  logic [3:0]    shadow_d [4];
  logic [3:0]    dig_in   [4];
  logic          tick;
  logic          latch;

  assign dig_in[0] = disp.dig0;
  assign dig_in[1] = disp.dig1;
  assign dig_in[2] = disp.dig2;
  assign dig_in[3] = disp.dig3;

  assign tick  = (cnt_q == CNT_LAST);
  assign latch = tick && (idx_q == 2'd3);

  // Shadow codes reset to 11 so the display is blank until the first latch.
  for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
    assign shadow_d[gi] = latch ? dig_in[gi] : shadow_q[gi];
    always_ff @(posedge clk) begin
      if (rst) shadow_q[gi] <= 4'd11;
      else     shadow_q[gi] <= shadow_d[gi];
    end
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    fc_d  = fc_q;
    ph_d  = ph_q;
    blk_d = blk_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (latch) begin
      blk_d = disp.blink;
      if (fc_q == FC_LAST) begin
        fc_d = '0;
        ph_d = ~ph_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
    if (tick) begin
      idx_d = idx_q + 2'd1;
      an_d  = ~(4'b0001 << idx_d);
      // Next-state shadow/blink/phase so slot 0 shows the values latched on this edge.
      seg_d = (ph_d && blk_d[idx_d]) ? 7'b1111111 : decode(shadow_d[idx_d]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd3;
      fc_q  <= '0;
      ph_q  <= 1'b0;
      blk_q <= 4'b0000;
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fc_q  <= fc_d;
      ph_q  <= ph_d;
      blk_q <= blk_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 and BLINK_FRAMES=2.
// Covers a vector table of digit patterns plus reset, tear-free latch and blink sequences.
module tb_seg7_scan_driver;
  localparam int RD = 4;
  localparam int BF = 2;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S6  = 7'b0000010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] SD  = 7'b0111111;
  localparam logic [6:0] SB  = 7'b1111111;

  typedef struct {
    logic [15:0] digs;   // {dig3, dig2, dig1, dig0}
    logic [27:0] exps;   // {seg slot3, slot2, slot1, slot0}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs [18];

  seg7_scan_driver_if dif ();

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] ea, input logic [6:0] es);
    tests++;
    if (dif.an !== ea || dif.seg !== es || dif.dp !== 1'b1) begin
      failed++;
      $display("FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
               name, dif.an, dif.seg, dif.dp, ea, es);
    end else begin
      $display("ok   %s: an=%b seg=%b", name, dif.an, dif.seg);
    end
  endtask

  task automatic set_digs(input logic [15:0] d);
    dif.dig0 = d[3:0];
    dif.dig1 = d[7:4];
    dif.dig2 = d[11:8];
    dif.dig3 = d[15:12];
  endtask

  task automatic next_slot();
    repeat (RD) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("in_reset", 4'b1111, SB);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] sweep [16];
    logic [6:0] exp_seg;
    logic       blank_tbl [6];

    sweep = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SD, SB, SB, SB, SB, SB};
    // Decode sweep on dig2; dig0=8, dig1=1, dig3=0 stay fixed.
    for (int i = 0; i < 16; i++) begin
      vecs[i].digs = {4'd0, 4'(i), 4'd1, 4'd8};
      vecs[i].exps = {S0, sweep[i], S1, S8};
    end
    vecs[16].digs = 16'hAAAA;
    vecs[16].exps = {SD, SD, SD, SD};
    vecs[17].digs = 16'hB3BB;
    vecs[17].exps = {SB, S3, SB, SB};

    dif.blink = 4'b0000;
    set_digs(16'h4321);

    // Reset and first scan.
    do_reset(2);
    repeat (RD) @(posedge clk);
    #1;
    chk("first_lit", 4'b1110, S1);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_mid_slot", 4'b1110, S1);
    repeat (2) @(posedge clk);
    #1;
    chk("scan_slot1", 4'b1101, S2);
    next_slot(); chk("scan_slot2", 4'b1011, S3);
    next_slot(); chk("scan_slot3", 4'b0111, S4);
    next_slot(); chk("scan_wrap", 4'b1110, S1);
    repeat (3) next_slot();

    // Table: inputs applied during slot 3 are shown in the next frame.
    for (int v = 0; v < 18; v++) begin
      set_digs(vecs[v].digs);
      for (int s = 0; s < 4; s++) begin
        next_slot();
        chk($sformatf("vec%0d_slot%0d", v, s), ~(4'b0001 << s), vecs[v].exps[s*7 +: 7]);
      end
    end

    // Tear-free latch: inputs change while slot 1 is displayed.
    set_digs(16'h5555);
    next_slot(); chk("tear_f0_slot0", 4'b1110, S5);
    next_slot(); chk("tear_f0_slot1", 4'b1101, S5);
    set_digs(16'h0000);
    next_slot(); chk("tear_f0_slot2", 4'b1011, S5);
    next_slot(); chk("tear_f0_slot3", 4'b0111, S5);
    for (int s = 0; s < 4; s++) begin
      next_slot();
      chk($sformatf("tear_f1_slot%0d", s), ~(4'b0001 << s), S0);
    end

    // Blink on digit 2. The phase becomes 1 at the 2nd latch after reset and flips every 2 latches.
    blank_tbl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    dif.blink = 4'b0100;
    set_digs(16'h4721);
    do_reset(1);
    for (int f = 0; f < 6; f++) begin
      next_slot(); chk($sformatf("blink_f%0d_slot0", f + 1), 4'b1110, S1);
      next_slot(); chk($sformatf("blink_f%0d_slot1", f + 1), 4'b1101, S2);
      exp_seg = blank_tbl[f] ? SB : S7;
      next_slot(); chk($sformatf("blink_f%0d_slot2", f + 1), 4'b1011, exp_seg);
      next_slot(); chk($sformatf("blink_f%0d_slot3", f + 1), 4'b0111, S4);
    end

    // Frame 7 has phase 1. Reset during its slot 2.
    next_slot(); next_slot(); next_slot();
    chk("pre_rst_slot2_blank", 4'b1011, SB);
    dif.blink = 4'b0101;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dark", 4'b1111, SB);
    rst = 1'b0;
    repeat (RD) @(posedge clk);
    #1;
    chk("midrst_restart_slot0", 4'b1110, S1);
    next_slot(); chk("midrst_slot1", 4'b1101, S2);
    next_slot(); chk("midrst_slot2_ph0", 4'b1011, S7);
    next_slot(); chk("midrst_slot3", 4'b0111, S4);
    next_slot(); chk("midrst_f2_slot0_blank", 4'b1110, SB);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
